// File: rtl/pipelined_addsub.sv
// pipelined_addsub: WIDTH-bit adder/subtractor split into STAGES carry-pipelined slices.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake (A_in, B_in, C_in, sub sampled on transfer)
//   A_in, B_in            operands
//   C_in                  carry-in (add) / borrow-in (sub)
//   sub                   0 = A + B + C_in, 1 = A - B - C_in
//   out_valid / out_ready output handshake
//   sum                   result, modulo 2^WIDTH
//   c_out                 carry-out (add) / not-borrow (sub)
//   ovf                   two's-complement signed overflow
//   zero                  sum == 0
//
// Stage k adds slice k using the registered carry from stage k-1. Operand bits not yet
// consumed ride forward in skew registers; finished sum slices accumulate in de-skew
// registers so that the full result leaves the last stage at once. The last stage's
// registers are the outputs. A single global enable stalls the whole pipe.

module pipelined_addsub #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic             C_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned W_S  = WIDTH / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  logic             w_en;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_c_eff;

  // Subtraction as A + ~B + ~C_in: inversion happens once, ahead of stage 0.
  assign w_b_eff = sub ? ~B_in : B_in;
  assign w_c_eff = C_in ^ sub;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LO = k * W_S;

    // Operand bits still unprocessed when entering this stage (slice k and above).
    logic [WIDTH-1:LO]    w_a_rem;
    logic [WIDTH-1:LO]    w_b_rem;
    logic                 w_ci;
    logic                 w_vi;
    logic [W_S:0]         w_add;
    logic [LO+W_S-1:0]    w_s_nx;

    logic                 r_v;
    logic                 r_c;
    logic [LO+W_S-1:0]    r_s;

    if (k == 0) begin : g_src
      assign w_a_rem = A_in;
      assign w_b_rem = w_b_eff;
      assign w_ci    = w_c_eff;
      assign w_vi    = in_valid;
      assign w_s_nx  = w_add[W_S-1:0];
    end else begin : g_src
      assign w_a_rem = g_stage[k-1].g_fwd.r_a;
      assign w_b_rem = g_stage[k-1].g_fwd.r_b;
      assign w_ci    = g_stage[k-1].r_c;
      assign w_vi    = g_stage[k-1].r_v;
      assign w_s_nx  = {w_add[W_S-1:0], g_stage[k-1].r_s};
    end

    assign w_add = {1'b0, w_a_rem[LO +: W_S]} + {1'b0, w_b_rem[LO +: W_S]}
                 + {{W_S{1'b0}}, w_ci};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
        r_s <= '0;
      end else if (w_en) begin
        r_v <= w_vi;
        r_c <= w_add[W_S];
        r_s <= w_s_nx;
      end
    end

    // Skew registers: only the slices later stages still need are carried.
    if (k < LAST) begin : g_fwd
      logic [WIDTH-1:LO+W_S] r_a;
      logic [WIDTH-1:LO+W_S] r_b;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_en) begin
          r_a <= w_a_rem[WIDTH-1:LO+W_S];
          r_b <= w_b_rem[WIDTH-1:LO+W_S];
        end
      end
    end
  end

  // Flags are formed from the last slice's inputs and the completed sum, then registered
  // alongside the final stage so every output field changes on the same edge.
  logic w_ovf_nx;
  logic w_zero_nx;
  logic r_ovf;
  logic r_zero;

  assign w_ovf_nx  = (g_stage[LAST].w_a_rem[WIDTH-1] == g_stage[LAST].w_b_rem[WIDTH-1]) &&
                     (g_stage[LAST].w_add[W_S-1] != g_stage[LAST].w_a_rem[WIDTH-1]);
  assign w_zero_nx = (g_stage[LAST].w_s_nx == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_en) begin
      r_ovf  <= w_ovf_nx;
      r_zero <= w_zero_nx;
    end
  end

  assign out_valid = g_stage[LAST].r_v;
  assign sum       = g_stage[LAST].r_s;
  assign c_out     = g_stage[LAST].r_c;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

  // Pipe advances whenever the output slot is empty or being drained.
  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: three instances (8/2, 16/4, 8/1) driven with directed
// operations and randomized streams, checked against an arithmetic reference model.

module tb_pipelined_addsub;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        i_v[3];
  logic        i_c[3];
  logic        i_s[3];
  logic        o_r[3];
  logic [15:0] i_a[3];
  logic [15:0] i_b[3];

  logic        o_rdy[3];
  logic        o_v[3];
  logic        o_c[3];
  logic        o_o[3];
  logic        o_z[3];
  logic [15:0] o_s[3];

  logic        rdy0, v0, c0, ov0, z0;
  logic [7:0]  s0;
  logic        rdy1, v1, c1, ov1, z1;
  logic [15:0] s1;
  logic        rdy2, v2, c2, ov2, z2;
  logic [7:0]  s2;

  int wid[3] = '{8, 16, 8};
  int stg[3] = '{2, 4, 1};

  int n_chk  = 0;
  int n_pass = 0;

  always_comb begin
    o_rdy[0] = rdy0; o_v[0] = v0; o_c[0] = c0; o_o[0] = ov0; o_z[0] = z0; o_s[0] = {8'h00, s0};
    o_rdy[1] = rdy1; o_v[1] = v1; o_c[1] = c1; o_o[1] = ov1; o_z[1] = z1; o_s[1] = s1;
    o_rdy[2] = rdy2; o_v[2] = v2; o_c[2] = c2; o_o[2] = ov2; o_z[2] = z2; o_s[2] = {8'h00, s2};
  end

  pipelined_addsub #(.WIDTH(8), .STAGES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(i_v[0]), .in_ready(rdy0),
    .A_in(i_a[0][7:0]), .B_in(i_b[0][7:0]), .C_in(i_c[0]), .sub(i_s[0]),
    .out_valid(v0), .out_ready(o_r[0]), .sum(s0), .c_out(c0), .ovf(ov0), .zero(z0)
  );

  pipelined_addsub #(.WIDTH(16), .STAGES(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(i_v[1]), .in_ready(rdy1),
    .A_in(i_a[1]), .B_in(i_b[1]), .C_in(i_c[1]), .sub(i_s[1]),
    .out_valid(v1), .out_ready(o_r[1]), .sum(s1), .c_out(c1), .ovf(ov1), .zero(z1)
  );

  pipelined_addsub #(.WIDTH(8), .STAGES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(i_v[2]), .in_ready(rdy2),
    .A_in(i_a[2][7:0]), .B_in(i_b[2][7:0]), .C_in(i_c[2]), .sub(i_s[2]),
    .out_valid(v2), .out_ready(o_r[2]), .sum(s2), .c_out(c2), .ovf(ov2), .zero(z2)
  );

  // Reference: plain integer arithmetic. Packing is {c_out, ovf, zero, sum[15:0]}.
  function automatic logic [18:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sb);
    longint m, ua, ub, sa, sbv, full, sres;
    logic [15:0] s;
    logic c, o;
    m   = longint'(1) << w;
    ua  = longint'(a);
    ub  = longint'(b);
    sa  = a[w-1] ? ua - m : ua;
    sbv = b[w-1] ? ub - m : ub;
    if (!sb) begin
      full = ua + ub + longint'(cin);
      sres = sa + sbv + longint'(cin);
      c    = (full >= m);
    end else begin
      full = ua - ub - longint'(cin);
      sres = sa - sbv - longint'(cin);
      c    = (full >= 0);
    end
    s = 16'(full & (m - 1));
    o = (sres < -(m / 2)) || (sres >= (m / 2));
    return {c, o, (s == 16'h0000), s};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle();
    for (int s = 0; s < 3; s++) begin
      i_v[s] = 1'b0; i_c[s] = 1'b0; i_s[s] = 1'b0; o_r[s] = 1'b1;
      i_a[s] = 16'h0; i_b[s] = 16'h0;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    for (int s = 0; s < 3; s++)
      chk($sformatf("%s_%0d", tag, s), {o_v[s], o_c[s], o_o[s], o_z[s], o_s[s]}, 32'h0);
  endtask

  // One isolated operation; checks acceptance, exact latency, fields and single delivery.
  task automatic do_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sb, input logic [18:0] exp,
                       input string tag);
    @(posedge clk); #1;
    idle();
    i_v[sel] = 1'b1; i_a[sel] = a; i_b[sel] = b; i_c[sel] = cin; i_s[sel] = sb;
    #1 chk({tag, "_rdy"}, o_rdy[sel], 1);
    @(posedge clk); #1;
    i_v[sel] = 1'b0;
    for (int k = 0; k < stg[sel] - 1; k++) begin
      chk($sformatf("%s_early%0d", tag, k), o_v[sel], 0);
      @(posedge clk); #1;
    end
    chk({tag, "_valid"}, o_v[sel], 1);
    chk({tag, "_sum"}, o_s[sel], exp[15:0]);
    chk({tag, "_flags"}, {o_c[sel], o_o[sel], o_z[sel]}, exp[18:16]);
    @(posedge clk); #1;
    chk({tag, "_nodup"}, o_v[sel], 0);
  endtask

  // Stream of n_ops operations; rnd=0 gives back-to-back input with a 3-cycle stall.
  task automatic stream(input int sel, input int n_ops, input bit rnd, input string tag);
    logic [18:0] q[$];
    logic [18:0] e;
    logic [18:0] cur;
    logic [18:0] hold_val;
    logic [15:0] mask;
    bit          held;
    int          sent, rcvd, cyc;
    mask = 16'((32'd1 << wid[sel]) - 1);
    sent = 0; rcvd = 0; cyc = 0; held = 0; hold_val = '0;
    idle();
    while (rcvd < n_ops && cyc < 20 * n_ops + 50) begin
      @(posedge clk); #1;
      if (rnd) begin
        o_r[sel] = ($urandom_range(0, 3) != 0);
        i_v[sel] = (sent < n_ops) && ($urandom_range(0, 2) != 0);
      end else begin
        o_r[sel] = !(cyc >= 4 && cyc <= 6);
        i_v[sel] = (sent < n_ops);
      end
      i_a[sel] = 16'($urandom) & mask;
      i_b[sel] = 16'($urandom) & mask;
      i_c[sel] = 1'($urandom);
      i_s[sel] = 1'($urandom);
      @(negedge clk);
      cur = {o_c[sel], o_o[sel], o_z[sel], o_s[sel]};
      if (held) chk({tag, "_hold"}, {o_v[sel], cur}, {1'b1, hold_val});
      if (o_v[sel] && !o_r[sel]) begin
        chk({tag, "_stall_rdy"}, o_rdy[sel], 0);
        held = 1; hold_val = cur;
      end else begin
        held = 0;
      end
      if (o_v[sel] && o_r[sel]) begin
        if (q.size() == 0) begin
          chk({tag, "_unexpected"}, o_v[sel], 0);
        end else begin
          e = q.pop_front();
          chk($sformatf("%s_sum%0d", tag, rcvd), o_s[sel], e[15:0]);
          chk($sformatf("%s_c%0d", tag, rcvd), o_c[sel], e[18]);
          chk($sformatf("%s_ovf%0d", tag, rcvd), o_o[sel], e[17]);
          chk($sformatf("%s_zero%0d", tag, rcvd), o_z[sel], e[16]);
          rcvd++;
        end
      end
      if (i_v[sel] && o_rdy[sel]) begin
        q.push_back(model(wid[sel], i_a[sel], i_b[sel], i_c[sel], i_s[sel]));
        sent++;
      end
      cyc++;
    end
    @(posedge clk); #1;
    idle();
    chk({tag, "_count"}, rcvd, n_ops);
    chk({tag, "_left"}, q.size(), 0);
    repeat (stg[sel] + 1) begin
      @(posedge clk); #1;
      chk({tag, "_drained"}, o_v[sel], 0);
    end
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #2 chk_all_zero("rst_async");
    repeat (2) @(posedge clk);
    #1 chk_all_zero("rst_hold");
    rst_n = 1'b1;
    #1;
    for (int s = 0; s < 3; s++) chk($sformatf("rst_rdy_%0d", s), o_rdy[s], 1);

    do_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 1'b1, 16'h0000}, "add_ff_01");
    do_op(0, 16'h007F, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 1'b0, 16'h0080}, "add_7f_01");
    do_op(0, 16'h0080, 16'h0080, 1'b0, 1'b0, {1'b1, 1'b1, 1'b1, 16'h0000}, "add_80_80");
    do_op(0, 16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 1'b0, 16'h00FE}, "sub_05_07");
    do_op(0, 16'h0010, 16'h0001, 1'b1, 1'b1, {1'b1, 1'b0, 1'b0, 16'h000E}, "sub_10_01");
    do_op(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 1'b1, 16'h0000}, "w16_ffff_1");
    do_op(1, 16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 1'b0, 16'h7FFF}, "w16_sub_ovf");
    do_op(2, 16'h00FF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 1'b1, 16'h0000}, "s1_ff_01");

    stream(0, 10, 1'b0, "bp");

    // Reset with two operations in flight.
    @(posedge clk); #1;
    idle();
    i_v[0] = 1'b1; i_a[0] = 16'h0011; i_b[0] = 16'h0022;
    @(posedge clk); #1;
    i_a[0] = 16'h0033; i_b[0] = 16'h0044;
    @(posedge clk); #1;
    i_v[0] = 1'b0;
    chk("inflight_valid", o_v[0], 1);
    rst_n = 1'b0;
    #1 chk_all_zero("rst_mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_no_stale", o_v[0], 0);
    end
    do_op(0, 16'h0012, 16'h0034, 1'b0, 1'b0, {1'b0, 1'b0, 1'b0, 16'h0046}, "post_rst");

    stream(1, 1000, 1'b1, "rnd16");
    stream(2, 1000, 1'b1, "rnd1");
    stream(0, 300, 1'b1, "rnd8");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
